// File: rtl/music_pkg.sv
// Shared constants for the song-playback path: note/duration widths,
// duration-FSM state encodings and event-type codes.
package music_pkg;

  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ADV  = 2'b10
  } sched_state_e;

  localparam logic TYPE_NOTE = 1'b0;
  localparam logic TYPE_DUR  = 1'b1;

endpackage : music_pkg

// File: rtl/voice_scheduler_if.sv
// Bundle between song reader (master) and voice scheduler (slave):
// event inputs, play/beat controls and the per-voice outputs.
interface voice_scheduler_if
  import music_pkg::*;
#(
  parameter int NUM_VOICES = 3
) ();

  logic                         play;
  logic                         beat;
  logic                         new_event;
  logic                         type_in;
  logic [NOTE_W-1:0]            note_in;
  logic [DUR_W-1:0]             duration_in;
  logic                         advance;
  logic [NUM_VOICES-1:0]        voice_load;
  logic [NUM_VOICES*NOTE_W-1:0] voice_note;
  logic [NUM_VOICES-1:0]        voice_active;
  logic                         note_dropped;

  modport master (
    output play, beat, new_event, type_in, note_in, duration_in,
    input  advance, voice_load, voice_note, voice_active, note_dropped
  );

  modport slave (
    input  play, beat, new_event, type_in, note_in, duration_in,
    output advance, voice_load, voice_note, voice_active, note_dropped
  );

endinterface : voice_scheduler_if

// File: rtl/voice_scheduler_voice_slot.sv
// One note-player voice: held note, remaining beats and active flag.
// A load always wins over a beat in the same cycle, so a freshly loaded
// count is never decremented on its load cycle.
module voice_slot
  import music_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              beat,
  input  logic              play,
  input  logic [NOTE_W-1:0] note_in,
  input  logic [DUR_W-1:0]  dur_in,
  output logic [NOTE_W-1:0] note_q,
  output logic [DUR_W-1:0]  remaining_q,
  output logic              active_q
);

  logic [NOTE_W-1:0] note_d;
  logic [DUR_W-1:0]  remaining_d;
  logic              active_d;

  // Next-state: load takes precedence, otherwise count down on a live beat.
  always_comb begin
    note_d      = note_q;
    remaining_d = remaining_q;
    if (load) begin
      note_d      = note_in;
      remaining_d = dur_in;
    end else if (beat && play && (remaining_q != DUR_W'(0))) begin
      remaining_d = remaining_q - DUR_W'(1);
    end else begin
      remaining_d = remaining_q;
    end
    active_d = (remaining_d != DUR_W'(0));
  end

  // Voice state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      note_q      <= NOTE_W'(0);
      remaining_q <= DUR_W'(0);
      active_q    <= 1'b0;
    end else begin
      note_q      <= note_d;
      remaining_q <= remaining_d;
      active_q    <= active_d;
    end
  end

endmodule : voice_slot

// File: rtl/voice_scheduler.sv
// Voice scheduler: allocates note events to voices and times duration
// events, returning a one-cycle advance pulse to the song reader.
// Build option VOICE_STEAL_EN: when defined, a note arriving with every
// voice busy steals the voice with the least remaining time (lowest index
// on ties); when undefined, the note is discarded and note_dropped pulses.
module voice_scheduler
  import music_pkg::*;
#(
  parameter int NUM_VOICES = 3
) (
  input  logic              clk,
  input  logic              reset,
  voice_scheduler_if.slave  bus
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic                         note_evt_s;
  logic                         dur_evt_s;
  logic                         tick_s;
  logic [NUM_VOICES-1:0]        active_s;
  logic [NUM_VOICES-1:0]        load_vec_s;
  logic [NOTE_W-1:0]            note_s [NUM_VOICES];
  logic [DUR_W-1:0]             rem_s  [NUM_VOICES];
  logic [NUM_VOICES*NOTE_W-1:0] voice_note_s;
  logic                         free_found_s;
  logic [IDX_W-1:0]             free_idx_s;
  logic                         drop_s;

  sched_state_e          state_q, state_d;
  logic [DUR_W-1:0]      wait_q, wait_d;
  logic                  advance_q, advance_d;
  logic [NUM_VOICES-1:0] voice_load_q, voice_load_d;
  logic                  note_dropped_q, note_dropped_d;

  assign note_evt_s = bus.new_event && (bus.type_in == TYPE_NOTE) &&
                      (bus.duration_in != DUR_W'(0));
  assign dur_evt_s  = bus.new_event && (bus.type_in == TYPE_DUR);
  assign tick_s     = bus.beat && bus.play;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
    voice_slot u_slot (
      .clk         (clk),
      .reset       (reset),
      .load        (load_vec_s[g]),
      .beat        (bus.beat),
      .play        (bus.play),
      .note_in     (bus.note_in),
      .dur_in      (bus.duration_in),
      .note_q      (note_s[g]),
      .remaining_q (rem_s[g]),
      .active_q    (active_s[g])
    );
    assign voice_note_s[g*NOTE_W +: NOTE_W] = note_s[g];
  end

  // Priority encoder: lowest-index idle voice (scan high to low, last hit wins).
  always_comb begin
    free_found_s = ~(&active_s);
    free_idx_s   = IDX_W'(0);
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      free_idx_s = (!active_s[i]) ? IDX_W'(i) : free_idx_s;
    end
  end

`ifdef VOICE_STEAL_EN
  logic [IDX_W-1:0] min_idx_s;
  logic [DUR_W-1:0] min_rem_s;

  // Min-finder over remaining counts; strict compare keeps the lower index on ties.
  always_comb begin
    logic less_v;
    less_v    = 1'b0;
    min_idx_s = IDX_W'(0);
    min_rem_s = rem_s[0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      less_v    = (rem_s[i] < min_rem_s);
      min_idx_s = less_v ? IDX_W'(i) : min_idx_s;
      min_rem_s = less_v ? rem_s[i]  : min_rem_s;
    end
  end
`endif

  // Allocation: pick the target voice for a note event or flag it as dropped.
  always_comb begin
    load_vec_s = '0;
    drop_s     = 1'b0;
    if (note_evt_s) begin
      if (free_found_s) begin
        load_vec_s[free_idx_s] = 1'b1;
      end else begin
`ifdef VOICE_STEAL_EN
        load_vec_s[min_idx_s] = 1'b1;
`else
        drop_s = 1'b1;
`endif
      end
    end else begin
      load_vec_s = '0;
    end
  end

  // Duration FSM next-state; a new duration event always restarts the wait
  // and silently abandons any wait or pending advance in flight.
  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    advance_d      = 1'b0;
    voice_load_d   = load_vec_s;
    note_dropped_d = drop_s;
    if (dur_evt_s) begin
      state_d = WAIT;
      wait_d  = bus.duration_in;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        WAIT: begin
          if (wait_q == DUR_W'(0)) begin
            state_d = ADV;
          end else if (tick_s) begin
            wait_d  = wait_q - DUR_W'(1);
            state_d = (wait_q == DUR_W'(1)) ? ADV : WAIT;
          end else begin
            state_d = WAIT;
          end
        end
        ADV: begin
          if (bus.play) begin
            advance_d = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = ADV;
          end
        end
        default: begin
          state_d = IDLE;
          wait_d  = DUR_W'(0);
        end
      endcase
    end
  end

  // FSM state, wait counter and registered pulse outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      wait_q         <= DUR_W'(0);
      advance_q      <= 1'b0;
      voice_load_q   <= '0;
      note_dropped_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      advance_q      <= advance_d;
      voice_load_q   <= voice_load_d;
      note_dropped_q <= note_dropped_d;
    end
  end

  assign bus.advance      = advance_q;
  assign bus.voice_load   = voice_load_q;
  assign bus.voice_note   = voice_note_s;
  assign bus.voice_active = active_s;
  assign bus.note_dropped = note_dropped_q;

endmodule : voice_scheduler

// File: tb/tb_voice_scheduler.sv
// Self-checking bench for voice_scheduler: directed scenarios followed by
// random traffic, all checked every cycle against a behavioural model.
module tb_voice_scheduler;
  import music_pkg::*;

  localparam int NV = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  voice_scheduler_if #(.NUM_VOICES(NV)) bus ();

  voice_scheduler #(.NUM_VOICES(NV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int adv_seen = 0;

  // Behavioural model: beats left per voice, notes, and a pending-wait record.
  int            m_rem  [NV];
  int            m_note [NV];
  bit            m_armed;
  bit            m_ready;
  int            m_left;
  logic [NV-1:0] m_load;
  bit            m_adv;
  bit            m_drop;

  function automatic void model_reset();
    for (int v = 0; v < NV; v++) begin
      m_rem[v]  = 0;
      m_note[v] = 0;
    end
    m_armed = 1'b0; m_ready = 1'b0; m_left = 0;
    m_load = '0; m_adv = 1'b0; m_drop = 1'b0;
  endfunction

  function automatic void model_step();
    int  target;
    int  best;
    bit  tick;
    tick   = bus.beat && bus.play;
    m_load = '0; m_adv = 1'b0; m_drop = 1'b0;
    target = -1;
    if (bus.new_event && bus.type_in == TYPE_NOTE && bus.duration_in != 0) begin
      for (int v = NV - 1; v >= 0; v--) if (m_rem[v] == 0) target = v;
      if (target < 0) begin
`ifdef VOICE_STEAL_EN
        best = 0;
        for (int v = 1; v < NV; v++) if (m_rem[v] < m_rem[best]) best = v;
        target = best;
`else
        best = 0;
        m_drop = 1'b1;
`endif
      end
    end
    for (int v = 0; v < NV; v++) begin
      if (v == target) begin
        m_rem[v] = int'(bus.duration_in);
        m_note[v] = int'(bus.note_in);
        m_load[v] = 1'b1;
      end else if (tick && m_rem[v] > 0) begin
        m_rem[v]--;
      end
    end
    if (bus.new_event && bus.type_in == TYPE_DUR) begin
      m_armed = 1'b1; m_ready = 1'b0; m_left = int'(bus.duration_in);
    end else if (m_ready) begin
      if (bus.play) begin
        m_adv = 1'b1; m_ready = 1'b0;
      end
    end else if (m_armed) begin
      if (m_left == 0) begin
        m_ready = 1'b1; m_armed = 1'b0;
      end else if (tick) begin
        m_left--;
        if (m_left == 0) begin
          m_ready = 1'b1; m_armed = 1'b0;
        end
      end
    end
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [NV*NOTE_W-1:0] en;
    logic [NV-1:0]        ea;
    for (int v = 0; v < NV; v++) begin
      en[v*NOTE_W +: NOTE_W] = NOTE_W'(m_note[v]);
      ea[v] = (m_rem[v] > 0);
    end
    cmp("voice_load",   32'(bus.voice_load),   32'(m_load));
    cmp("voice_note",   32'(bus.voice_note),   32'(en));
    cmp("voice_active", 32'(bus.voice_active), 32'(ea));
    cmp("advance",      32'(bus.advance),      32'(m_adv));
    cmp("note_dropped", 32'(bus.note_dropped), 32'(m_drop));
  endtask

  task automatic step(input bit b);
    bus.beat = b;
    @(posedge clk);
    model_step();
    @(negedge clk);
    bus.new_event = 1'b0;
    bus.beat      = 1'b0;
    check_all();
    if (bus.advance) adv_seen++;
  endtask

  task automatic note_ev(input int n, input int d, input bit b);
    bus.new_event = 1'b1; bus.type_in = TYPE_NOTE;
    bus.note_in = NOTE_W'(n); bus.duration_in = DUR_W'(d);
    step(b);
  endtask

  task automatic dur_ev(input int d, input bit b);
    bus.new_event = 1'b1; bus.type_in = TYPE_DUR;
    bus.note_in = NOTE_W'(0); bus.duration_in = DUR_W'(d);
    step(b);
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, "_advance"}, 32'(bus.advance),      32'd0);
    cmp({tag, "_load"},    32'(bus.voice_load),   32'd0);
    cmp({tag, "_note"},    32'(bus.voice_note),   32'd0);
    cmp({tag, "_active"},  32'(bus.voice_active), 32'd0);
    cmp({tag, "_drop"},    32'(bus.note_dropped), 32'd0);
  endtask

  initial begin
    logic [NV-1:0] ld;
    int adv_at;
    bus.play = 1'b1; bus.beat = 1'b0; bus.new_event = 1'b0;
    bus.type_in = TYPE_NOTE; bus.note_in = '0; bus.duration_in = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
    step(1'b0);

    // Chord of three notes, then four beats.
    note_ev(32'h10, 4, 1'b0); cmp("chord_ld0", 32'(bus.voice_load), 32'b001);
    note_ev(32'h14, 4, 1'b0); cmp("chord_ld1", 32'(bus.voice_load), 32'b010);
    note_ev(32'h17, 2, 1'b0); cmp("chord_ld2", 32'(bus.voice_load), 32'b100);
    step(1'b1); step(1'b0); step(1'b1); step(1'b0);
    cmp("chord_2beats", 32'(bus.voice_active), 32'b011);
    step(1'b1); step(1'b0); step(1'b1); step(1'b0);
    cmp("chord_4beats", 32'(bus.voice_active), 32'b000);

    // Zero-length note is ignored; zero-length wait advances two cycles later.
    note_ev(32'h05, 0, 1'b0);
    cmp("zero_note_ld", 32'(bus.voice_load), 32'd0);
    dur_ev(0, 1'b0);
    step(1'b0); cmp("dur0_early", 32'(bus.advance), 32'd0);
    step(1'b0); cmp("dur0_adv",   32'(bus.advance), 32'd1);

    // Wait of 3 beats with beats every 5 cycles.
    adv_seen = 0; adv_at = -1;
    dur_ev(3, 1'b0);
    for (int k = 0; k < 25; k++) begin
      step((k % 5) == 4);
      if (bus.advance && adv_at < 0) adv_at = k;
    end
    cmp("dur3_count", 32'(adv_seen), 32'd1);
    cmp("dur3_time",  32'(adv_at),   32'd15);

    // Fourth note while voices hold 4, 1, 3.
    note_ev(32'h21, 5, 1'b0); note_ev(32'h22, 2, 1'b0); note_ev(32'h23, 4, 1'b0);
    step(1'b1);
    note_ev(32'h24, 5, 1'b0);
`ifdef VOICE_STEAL_EN
    cmp("steal_ld",   32'(bus.voice_load),   32'b010);
    cmp("steal_drop", 32'(bus.note_dropped), 32'd0);
`else
    cmp("full_ld",   32'(bus.voice_load),   32'b000);
    cmp("full_drop", 32'(bus.note_dropped), 32'd1);
`endif
    for (int k = 0; k < 7; k++) begin
      step(1'b1); step(1'b0);
    end

    // play=0 mid-wait freezes wait and voices.
    note_ev(32'h30, 6, 1'b0);
    dur_ev(4, 1'b0);
    step(1'b1); step(1'b1);
    adv_seen = 0;
    bus.play = 1'b0;
    for (int k = 0; k < 10; k++) step((k % 3) == 0);
    cmp("pause_no_adv", 32'(adv_seen), 32'd0);
    bus.play = 1'b1;
    step(1'b1); step(1'b0); step(1'b1); step(1'b0);
    cmp("pause_resume_adv", 32'(bus.advance), 32'd1);

    // Load coincident with beat, duration 1.
    note_ev(32'h3F, 1, 1'b1);
    ld = bus.voice_load;
    cmp("beatload_active", 32'(bus.voice_active & ld), 32'(ld));
    step(1'b0); step(1'b0); step(1'b0);
    cmp("beatload_hold", 32'(bus.voice_active & ld), 32'(ld));
    step(1'b1);
    cmp("beatload_clear", 32'(bus.voice_active & ld), 32'd0);

    // Reset while waiting with voices active.
    note_ev(32'h11, 7, 1'b0);
    dur_ev(5, 1'b0);
    step(1'b1);
    reset = 1'b0;
    #1;
    check_zero("midreset");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    adv_seen = 0;
    for (int k = 0; k < 20; k++) step((k % 2) == 0);
    cmp("postreset_no_adv", 32'(adv_seen), 32'd0);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      bus.play        = ($urandom_range(0, 9) != 0);
      bus.new_event   = ($urandom_range(0, 4) == 0);
      bus.type_in     = ($urandom_range(0, 2) == 0) ? TYPE_DUR : TYPE_NOTE;
      bus.note_in     = NOTE_W'($urandom);
      bus.duration_in = DUR_W'($urandom_range(0, 7));
      step($urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_voice_scheduler
